pull_burst_reader: RTL and testbench

Drain side of the pull path: pops request descriptors from a `req` queue, then dequeues exactly the requested number of data beats from a `fifo` instance. It re-emits those beats as a framed valid/ready stream with start-of-packet and end-of-packet markers. It sits downstream of `pull`, reading both the request queue and the data FIFO that `pull` fills.

---
 rtl/pull_pkg.sv | 15 +
 rtl/pull_out_reg.sv | 51 +++++
 rtl/pull_burst_reader.sv | 116 +++++++++++
 tb/tb_pull_burst_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pull_pkg.sv
// Purpose: shared types and default widths for the pull-path drain logic.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pull_pkg;

  localparam int PULL_LEN_WIDTH  = 5;
  localparam int PULL_DATA_WIDTH = 32;

  // Drain FSM: IDLE waits for a request descriptor, BURST pops its beats.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } pull_rd_state_e;

endpackage

// File: rtl/pull_out_reg.sv
// Purpose: single-entry valid/ready output register carrying data + sop + eop.
// Latency: one cycle from load to out_valid.
// Backpressure: contents held while out_valid & !out_ready; can_load reports a free slot.
//
// Ports:
//   clk, rst_n            clock and async active-low reset
//   load                  capture in_* this cycle (only when can_load)
//   can_load              register empty or being drained this cycle
//   in_data/in_sop/in_eop beat to capture
//   out_valid/out_data/out_sop/out_eop/out_ready  downstream stream
module pull_out_reg
  import pull_pkg::*;
#(
  parameter int DATA_WIDTH = PULL_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  output logic                  can_load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  input  logic                  out_ready
);

  // A full register frees up in the same cycle its beat is accepted, so the
  // producer can refill it back-to-back (no bubble, but a comb path from ready).
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_sop   <= in_sop;
      out_eop   <= in_eop;
    end else if (out_ready) begin
      // Payload is left as-is; only the valid flag drops after acceptance.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pull_burst_reader.sv
// Purpose: pops a length descriptor, then pops exactly that many data beats and re-emits them framed with sop/eop.
// Latency: data pop at cycle t appears on out_* at t+1; one IDLE cycle between bursts.
// Backpressure: registered output stage; dequeue_w is gated combinationally by out_ready, data FIFO stalls wait indefinitely.
//
// Ports:
//   deq_val/deq_len/deq_req           request queue head (show-ahead) and pop
//   data_valid_r/rdata_r/dequeue_w    data FIFO head (show-ahead) and pop
//   out_valid/out_data/out_sop/out_eop/out_ready  framed output stream
//   busy, len_zero_err, burst_cnt     status: activity, dropped zero-length request, completed bursts
module pull_burst_reader
  import pull_pkg::*;
#(
  parameter int DATA_WIDTH = PULL_DATA_WIDTH,
  parameter int LEN_WIDTH  = PULL_LEN_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  deq_val,
  input  logic [LEN_WIDTH-1:0]  deq_len,
  output logic                  deq_req,
  input  logic                  data_valid_r,
  input  logic [DATA_WIDTH-1:0] rdata_r,
  output logic                  dequeue_w,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  len_zero_err,
  output logic [CNT_WIDTH-1:0]  burst_cnt
);

  pull_rd_state_e       state_q, state_d;
  logic [LEN_WIDTH-1:0] remaining_q;
  logic                 first_q;
  logic                 len_zero_err_q;
  logic [CNT_WIDTH-1:0] burst_cnt_q;
  logic                 can_load;
  logic                 last_beat;

  assign last_beat = (remaining_q == LEN_WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    deq_req   = 1'b0;
    dequeue_w = 1'b0;
    case (state_q)
      IDLE: begin
        if (deq_val) begin
          deq_req = 1'b1;
          // A zero-length descriptor is consumed but never opens a burst.
          if (deq_len != '0) begin
            state_d = BURST;
          end
        end
      end
      BURST: begin
        if (data_valid_r && can_load) begin
          dequeue_w = 1'b1;
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      remaining_q    <= '0;
      first_q        <= 1'b0;
      len_zero_err_q <= 1'b0;
      burst_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      len_zero_err_q <= 1'b0;
      if (deq_req) begin
        remaining_q    <= deq_len;
        first_q        <= (deq_len != '0);
        len_zero_err_q <= (deq_len == '0);
      end else if (dequeue_w) begin
        remaining_q <= remaining_q - LEN_WIDTH'(1);
        first_q     <= 1'b0;
      end
      if (out_valid && out_ready && out_eop) begin
        burst_cnt_q <= burst_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  pull_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dequeue_w),
    .can_load (can_load),
    .in_data  (rdata_r),
    .in_sop   (first_q),
    .in_eop   (last_beat),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_ready(out_ready)
  );

  assign busy         = (state_q != IDLE) || out_valid;
  assign len_zero_err = len_zero_err_q;
  assign burst_cnt    = burst_cnt_q;

endmodule

// File: tb/tb_pull_burst_reader.sv
// Purpose: randomized and directed bench for pull_burst_reader against a burst-level reference model.
// Latency: n/a.
// Backpressure: out_ready driven always-high, in a 1,0,0 pattern, or randomly; data FIFO may starve.
module tb_pull_burst_reader;

  localparam int DW = 32;
  localparam int LW = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          deq_val;
  logic [LW-1:0] deq_len;
  logic          deq_req;
  logic          data_valid_r;
  logic [DW-1:0] rdata_r;
  logic          dequeue_w;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic          out_ready;
  logic          busy;
  logic          len_zero_err;
  logic [CW-1:0] burst_cnt;

  always #5 clk = ~clk;

  pull_burst_reader #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .deq_val     (deq_val),
    .deq_len     (deq_len),
    .deq_req     (deq_req),
    .data_valid_r(data_valid_r),
    .rdata_r     (rdata_r),
    .dequeue_w   (dequeue_w),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_ready   (out_ready),
    .busy        (busy),
    .len_zero_err(len_zero_err),
    .burst_cnt   (burst_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  // Upstream emulation: request queue and data FIFO contents.
  int unsigned   rq[$];
  logic [DW-1:0] dq[$];
  // Reference model: beats still to be emitted, in order, with framing.
  beat_t         exq[$];

  int    n_chk;
  int    n_pass;
  int    credit;     // beats still owed by the accepted request
  bit    ov_m;       // model of output register occupancy
  beat_t ov_b;       // beat the output register should hold
  int    cnt_m;      // completed bursts since reset
  bit    zero_pend;  // a zero-length request was consumed last cycle
  int    starve;     // cycles the data FIFO is forced to look empty
  int    rdy_mode;   // 0: always ready, 1: 1,0,0 pattern, 2: random
  int    cyc;
  int    pops_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_req(input int len);
    beat_t b;
    logic [DW-1:0] d;
    rq.push_back(len);
    for (int i = 0; i < len; i++) begin
      d = $urandom;
      dq.push_back(d);
      b.data = d;
      b.sop  = (i == 0);
      b.eop  = (i == len - 1);
      exq.push_back(b);
    end
  endtask

  task automatic cycle();
    int unsigned l;
    bit exp_dw;
    @(negedge clk);
    cyc++;
    deq_val      = (rq.size() > 0);
    deq_len      = deq_val ? LW'(rq[0]) : '0;
    data_valid_r = (dq.size() > 0) && (starve == 0);
    rdata_r      = (dq.size() > 0) ? dq[0] : '0;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 3 == 0);
      default: out_ready = ($urandom % 3 != 0);
    endcase
    #1;
    exp_dw = (credit > 0) && data_valid_r && (!ov_m || out_ready);
    chk("deq_req", deq_req, (credit == 0) && deq_val);
    chk("dequeue_w", dequeue_w, exp_dw);
    chk("out_valid", out_valid, ov_m);
    if (ov_m) begin
      chk("out_data", out_data, ov_b.data);
      chk("out_sop", out_sop, ov_b.sop);
      chk("out_eop", out_eop, ov_b.eop);
    end
    chk("busy", busy, (credit > 0) || ov_m);
    chk("len_zero_err", len_zero_err, zero_pend);
    chk("burst_cnt", burst_cnt, cnt_m % (1 << CW));

    zero_pend = 1'b0;
    if (ov_m && out_ready) begin
      if (ov_b.eop) cnt_m++;
      ov_m = 1'b0;
    end
    if (deq_req && rq.size() > 0) begin
      l = rq.pop_front();
      if (l == 0) zero_pend = 1'b1;
      else credit = l;
    end
    if (dequeue_w && dq.size() > 0) begin
      void'(dq.pop_front());
      if (credit > 0) credit--;
      pops_seen++;
      if (exq.size() > 0) begin
        ov_b = exq.pop_front();
        ov_m = 1'b1;
      end else begin
        chk("exp_underflow", 1'b1, 1'b0);
      end
    end
    if (starve > 0) starve--;
    else if (rdy_mode == 2 && $urandom % 10 == 0) starve = $urandom_range(1, 4);
  endtask

  task automatic run_idle(input int maxc);
    int n;
    n = 0;
    while ((rq.size() > 0 || dq.size() > 0 || credit > 0 || ov_m || zero_pend) && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", n < maxc, 1'b1);
    cycle();
  endtask

  task automatic wait_pops(input int npops, input int maxc);
    int base;
    int n;
    base = pops_seen;
    n = 0;
    while (pops_seen < base + npops && n < maxc) begin
      cycle();
      n++;
    end
    chk("pops_in_budget", n < maxc, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    deq_val      = 1'b0;
    deq_len      = '0;
    data_valid_r = 1'b0;
    rdata_r      = '0;
    out_ready    = 1'b0;
    #1;
    chk("rst_deq_req", deq_req, 1'b0);
    chk("rst_dequeue_w", dequeue_w, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_sop", out_sop, 1'b0);
    chk("rst_out_eop", out_eop, 1'b0);
    chk("rst_len_zero_err", len_zero_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_burst_cnt", burst_cnt, '0);
    rq.delete();
    dq.delete();
    exq.delete();
    credit    = 0;
    ov_m      = 1'b0;
    cnt_m     = 0;
    zero_pend = 1'b0;
    starve    = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; pops_seen = 0; rdy_mode = 0;
    credit = 0; ov_m = 1'b0; ov_b = '0; cnt_m = 0; zero_pend = 1'b0; starve = 0;
    rst_n = 1'b0; deq_val = 1'b0; deq_len = '0; data_valid_r = 1'b0;
    rdata_r = '0; out_ready = 1'b0;
    do_reset();

    // Three-beat burst with free-running output.
    rdy_mode = 0;
    push_req(3);
    run_idle(50);
    chk("burst_cnt_after_first", burst_cnt, 1);

    // Single-beat burst: sop and eop on the same beat.
    push_req(1);
    run_idle(50);

    // Four beats under a stalling consumer.
    rdy_mode = 1;
    push_req(4);
    run_idle(100);

    // Zero-length request is dropped, then a two-beat burst.
    rdy_mode = 0;
    push_req(0);
    push_req(2);
    run_idle(50);

    // Data FIFO runs dry for ten cycles after two beats.
    push_req(5);
    wait_pops(2, 50);
    starve = 10;
    run_idle(100);

    // Randomized back-to-back requests, random stalls on both sides.
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) push_req($urandom_range(0, 31));
    run_idle(5000);

    // Reset in the middle of a four-beat burst.
    rdy_mode = 0;
    push_req(4);
    wait_pops(2, 50);
    do_reset();
    push_req(2);
    run_idle(50);

    // Counter wrap: one burst so far, 2^CW-1 more bring it back to zero.
    for (int i = 0; i < (1 << CW) - 1; i++) push_req(1);
    run_idle(3000);
    chk("burst_cnt_wrap", burst_cnt, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
